antenna_period_tracker: RTL

ANTENNA_PERIOD_TRACKER -- requirements
Module: antenna_period_tracker

---
 rtl/antenna_period_tracker.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/antenna_period_tracker.sv
// Measures the period of the synchronized antenna feedback, locks onto a stable in-range
// signal and strobes the tracked period out. Optional averaging: PERIOD_TRACKER_AVERAGE_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | tracking disabled, counters cleared
// ARM     | enabled, waiting for the first rising edge to start timing
// MEASURE | timing the interval between successive rising edges
module antenna_period_tracker #(
  parameter int PERIOD_WIDTH   = 16,
  parameter int INITIAL_PERIOD = 70,
  parameter int MIN_PERIOD     = 20,
  parameter int MAX_PERIOD     = 200,
  parameter int LOCK_COUNT     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    antenna,
  output logic [PERIOD_WIDTH-1:0] period_out,
  output logic                    set_period,
  output logic                    locked
);

`ifdef PERIOD_TRACKER_AVERAGE_EN
  localparam int LOCK_TARGET = (LOCK_COUNT > 4) ? LOCK_COUNT : 4;
`else
  localparam int LOCK_TARGET = LOCK_COUNT;
`endif
  localparam int RUN_W = $clog2(LOCK_TARGET + 1);

  localparam logic [PERIOD_WIDTH-1:0] MIN_P     = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] MAX_P     = PERIOD_WIDTH'(MAX_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_P = PERIOD_WIDTH'(MAX_PERIOD + 1);
  localparam logic [PERIOD_WIDTH-1:0] CNT_SAT   = '1;
  localparam logic [RUN_W-1:0]        RUN_FULL  = RUN_W'(LOCK_TARGET);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0]        run_q, run_d;
  logic                    locked_d, set_d;
  logic [PERIOD_WIDTH-1:0] period_d, new_period;
  logic                    sync1_q, sync2_q, sync_prev_q;
  logic                    rise, timeout, in_range, valid, reject;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync1_q     <= antenna;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  assign rise     = sync2_q & ~sync_prev_q;
  // cnt_q holds cycles elapsed since the last edge, so on an edge it is the period itself
  assign timeout  = (state_q == MEASURE) && (cnt_q >= TIMEOUT_P);
  assign in_range = (cnt_q >= MIN_P) && (cnt_q <= MAX_P);
  assign valid    = (state_q == MEASURE) && rise && !timeout && in_range;
  assign reject   = (state_q == MEASURE) && rise && !timeout && !in_range;

`ifdef PERIOD_TRACKER_AVERAGE_EN
  logic [PERIOD_WIDTH-1:0] hist_q [4];
  logic [PERIOD_WIDTH+1:0] sum_q, sum_new;
  logic                    hist_clr, hist_push;

  assign hist_clr   = !enable || timeout || reject;
  assign hist_push  = enable && valid;
  // running sum of the four newest periods once the current one replaces the oldest
  assign sum_new    = sum_q - {2'b00, hist_q[3]} + {2'b00, cnt_q};
  assign new_period = sum_new[PERIOD_WIDTH+1:2];

  always_ff @(posedge clock) begin
    if (reset || hist_clr) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      sum_q <= '0;
    end else if (hist_push) begin
      hist_q[0] <= cnt_q;
      for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
      sum_q <= sum_new;
    end
  end
`else
  assign new_period = cnt_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    locked_d = locked;
    period_d = period_out;
    set_d    = 1'b0;
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      run_d    = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = PERIOD_WIDTH'(1);
          end
        end
        MEASURE: begin
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + PERIOD_WIDTH'(1);
          if (timeout) begin
            run_d    = '0;
            locked_d = 1'b0;
            // an edge landing on the timeout cycle still opens the next measurement
            if (rise) begin
              cnt_d = PERIOD_WIDTH'(1);
            end else begin
              state_d = ARM;
              cnt_d   = '0;
            end
          end else if (valid) begin
            cnt_d    = PERIOD_WIDTH'(1);
            run_d    = (run_q == RUN_FULL) ? run_q : run_q + RUN_W'(1);
            locked_d = (run_d == RUN_FULL);
            if (locked) begin
              set_d    = 1'b1;
              period_d = new_period;
            end
          end else if (reject) begin
            cnt_d    = PERIOD_WIDTH'(1);
            run_d    = '0;
            locked_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      run_q      <= '0;
      locked     <= 1'b0;
      set_period <= 1'b0;
      period_out <= PERIOD_WIDTH'(INITIAL_PERIOD);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      locked     <= locked_d;
      set_period <= set_d;
      period_out <= period_d;
    end
  end

endmodule
